// File: rtl/pmbist_microcode_container.sv
// Programmable memory-BIST sequencer: a writable microcode store executed one
// instruction per clock, emitting registered NOP/WRITE/READ ops with X/Y address and data.
module pmbist_microcode_container #(
  parameter int AX_WIDTH = 2,
  parameter int AY_WIDTH = 2,
  parameter int D_WIDTH  = 2,
  parameter int UC_DEPTH = 16,
  parameter int UC_W     = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_ucode_we,
  input  logic [$clog2(UC_DEPTH)-1:0] i_ucode_addr,
  input  logic [UC_W-1:0]             i_ucode_wdata,
  output logic [UC_W-1:0]             o_ucode_rdata,
  input  logic                        i_start,
  output logic [1:0]                  o_op_cmd,
  output logic [AX_WIDTH-1:0]         o_addr_x,
  output logic [AY_WIDTH-1:0]         o_addr_y,
  output logic [D_WIDTH-1:0]          o_data,
  output logic                        o_done
);

  localparam int UA_W = $clog2(UC_DEPTH);
  localparam int IW   = AX_WIDTH + AY_WIDTH;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] FL_NEXT = 2'd0;
  localparam logic [1:0] FL_LOOP = 2'd1;
  localparam logic [1:0] FL_JUMP = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [UA_W-1:0]   pc, pc_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              dir, dir_nxt;
  logic              bg_inv, bg_nxt;
  logic [UC_W-1:0]   store [UC_DEPTH];

  logic [1:0]          op_nxt;
  logic [AX_WIDTH-1:0] x_nxt;
  logic [AY_WIDTH-1:0] y_nxt;
  logic [D_WIDTH-1:0]  data_nxt;
  logic                done_nxt;

  // March X-scan program loaded at reset: W0 up, R0/W1 up, R1/W0 down, R0 up, then inverted pass.
  function automatic logic [UC_W-1:0] default_word(input int unsigned i);
    case (i)
      0:       default_word = UC_W'(12'h011);
      1:       default_word = UC_W'(12'h002);
      2:       default_word = UC_W'(12'h455);
      4:       default_word = UC_W'(12'h006);
      5:       default_word = UC_W'(12'h511);
      7:       default_word = UC_W'(12'h1F2);
      default: default_word = '0;
    endcase
  endfunction

  logic [UC_W-1:0] instr;
  logic [1:0]      op, flow;
  logic            dinv, y_fast, flip, idx_last, unused_bits;
  logic [UA_W-1:0] tgt_pc, pc_inc;
  logic [IW-1:0]   idx_step;

  assign instr       = store[pc];
  assign op          = instr[1:0];
  assign dinv        = instr[2];
  assign y_fast      = instr[3];
  assign flow        = instr[5:4];
  assign tgt_pc      = UA_W'(instr[9:6]);
  assign flip        = instr[10];
  assign unused_bits = ^instr[UC_W-1:11];
  assign pc_inc      = pc + UA_W'(1);
  assign idx_last    = dir ? (idx == '0) : (idx == '1);
  assign idx_step    = dir ? (idx - IW'(1)) : (idx + IW'(1));

  assign o_ucode_rdata = store[i_ucode_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    idx_nxt   = idx;
    dir_nxt   = dir;
    bg_nxt    = bg_inv;
    case (state)
      S_IDLE: if (i_start) begin
        state_nxt = S_RUN;
        pc_nxt    = '0;
        idx_nxt   = '0;
        dir_nxt   = 1'b0;
        bg_nxt    = 1'b0;
      end
      S_RUN: begin
        case (flow)
          FL_NEXT: begin
            pc_nxt = pc_inc;
            if (flip) begin
              dir_nxt = ~dir;
              idx_nxt = {IW{~dir}};
            end
            if (pc == UA_W'(UC_DEPTH - 1)) state_nxt = S_DONE;
          end
          FL_JUMP: pc_nxt = tgt_pc;
          default: begin
            // LOOP and LOOP_END share the not-last behaviour; they differ only at the scan end.
            if (!idx_last) begin
              idx_nxt = idx_step;
              pc_nxt  = tgt_pc;
            end else if (flow == FL_LOOP) begin
              dir_nxt = dir ^ flip;
              idx_nxt = {IW{dir ^ flip}};
              pc_nxt  = pc_inc;
            end else if (!bg_inv) begin
              bg_nxt  = 1'b1;
              dir_nxt = 1'b0;
              idx_nxt = '0;
              pc_nxt  = '0;
            end else begin
              state_nxt = S_DONE;
            end
          end
        endcase
      end
      S_DONE:  if (!i_start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    op_nxt   = OP_NOP;
    x_nxt    = o_addr_x;
    y_nxt    = o_addr_y;
    data_nxt = o_data;
    done_nxt = 1'b0;
    case (state)
      S_RUN: begin
        op_nxt   = (op == 2'd3) ? OP_NOP : op;
        data_nxt = {D_WIDTH{bg_inv ^ dinv}};
        if (y_fast) begin
          y_nxt = idx[AY_WIDTH-1:0];
          x_nxt = idx[IW-1:AY_WIDTH];
        end else begin
          x_nxt = idx[AX_WIDTH-1:0];
          y_nxt = idx[IW-1:AX_WIDTH];
        end
      end
      S_DONE:  done_nxt = i_start;
      default: done_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      idx      <= '0;
      dir      <= 1'b0;
      bg_inv   <= 1'b0;
      o_op_cmd <= OP_NOP;
      o_addr_x <= '0;
      o_addr_y <= '0;
      o_data   <= '0;
      o_done   <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      idx      <= idx_nxt;
      dir      <= dir_nxt;
      bg_inv   <= bg_nxt;
      o_op_cmd <= op_nxt;
      o_addr_x <= x_nxt;
      o_addr_y <= y_nxt;
      o_data   <= data_nxt;
      o_done   <= done_nxt;
    end
  end

  // Store writes are only accepted while idle so a running program cannot be altered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < UC_DEPTH; i++) store[i] <= default_word(i);
    end else if (state == S_IDLE && i_ucode_we) begin
      store[i_ucode_addr] <= i_ucode_wdata;
    end
  end

endmodule

// File: tb/tb_pmbist_microcode_container.sv
// Directed bench for the BIST sequencer: default March program, a loaded
// y-fast program, write blocking outside IDLE, and asynchronous reset mid-run.
module tb_pmbist_microcode_container;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ucode_we;
  logic [3:0]  i_ucode_addr;
  logic [11:0] i_ucode_wdata;
  logic [11:0] o_ucode_rdata;
  logic        i_start;
  logic [1:0]  o_op_cmd;
  logic [1:0]  o_addr_x;
  logic [1:0]  o_addr_y;
  logic [1:0]  o_data;
  logic        o_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] op;
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] d;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pmbist_microcode_container dut (
    .clk(clk), .rst_n(rst_n), .i_ucode_we(i_ucode_we), .i_ucode_addr(i_ucode_addr),
    .i_ucode_wdata(i_ucode_wdata), .o_ucode_rdata(o_ucode_rdata), .i_start(i_start),
    .o_op_cmd(o_op_cmd), .o_addr_x(o_addr_x), .o_addr_y(o_addr_y), .o_data(o_data),
    .o_done(o_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input int a, input logic [1:0] d, input bit yf);
    exp_t e;
    e.op = op;
    e.d  = d;
    if (yf) begin
      e.y = 2'(a % 4);
      e.x = 2'(a / 4);
    end else begin
      e.x = 2'(a % 4);
      e.y = 2'(a / 4);
    end
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_queue(input string name);
    for (int i = 0; i < q.size(); i++) begin
      tick();
      check($sformatf("%s_op%0d", name, i), 32'(o_op_cmd), 32'(q[i].op));
      if (q[i].op != 2'd0) begin
        check($sformatf("%s_x%0d", name, i), 32'(o_addr_x), 32'(q[i].x));
        check($sformatf("%s_y%0d", name, i), 32'(o_addr_y), 32'(q[i].y));
        check($sformatf("%s_d%0d", name, i), 32'(o_data), 32'(q[i].d));
      end
      check($sformatf("%s_busy%0d", name, i), 32'(o_done), 32'd0);
    end
  endtask

  initial begin
    logic [1:0] inv;
    rst_n = 1'b0;
    i_start = 1'b1;
    i_ucode_we = 1'b0;
    i_ucode_addr = 4'd7;
    i_ucode_wdata = '0;
    repeat (2) tick();

    // Reset state and default store contents
    check("rst_op", 32'(o_op_cmd), 32'd0);
    check("rst_x", 32'(o_addr_x), 32'd0);
    check("rst_y", 32'(o_addr_y), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rom7", 32'(o_ucode_rdata), 32'h1F2);
    i_ucode_addr = 4'd2;
    #1;
    check("rom2", 32'(o_ucode_rdata), 32'h455);

    rst_n = 1'b1;
    tick();
    check("idle_to_run_op", 32'(o_op_cmd), 32'd0);

    // Default March program: two passes, second with inverted background
    for (int p = 0; p < 2; p++) begin
      inv = (p == 1) ? 2'b11 : 2'b00;
      for (int a = 0; a < 16; a++) push(2'd1, a, 2'b00 ^ inv, 1'b0);
      for (int a = 0; a < 16; a++) begin
        push(2'd2, a, 2'b00 ^ inv, 1'b0);
        push(2'd1, a, 2'b11 ^ inv, 1'b0);
      end
      push(2'd0, 0, 2'b00, 1'b0);
      for (int a = 15; a >= 0; a--) begin
        push(2'd2, a, 2'b11 ^ inv, 1'b0);
        push(2'd1, a, 2'b00 ^ inv, 1'b0);
      end
      push(2'd0, 0, 2'b00, 1'b0);
      for (int a = 0; a < 16; a++) push(2'd2, a, 2'b00 ^ inv, 1'b0);
    end
    check("default_len", 32'(q.size()), 32'd196);
    run_queue("dflt");
    q.delete();

    tick();
    check("dflt_end_op", 32'(o_op_cmd), 32'd0);
    check("dflt_done", 32'(o_done), 32'd1);
    tick();
    check("dflt_done_hold", 32'(o_done), 32'd1);

    // Writes while DONE are ignored
    i_ucode_we = 1'b1;
    i_ucode_addr = 4'd5;
    i_ucode_wdata = 12'hFFF;
    tick();
    i_ucode_we = 1'b0;
    check("done_write_blocked", 32'(o_ucode_rdata), 32'h511);

    i_start = 1'b0;
    tick();
    check("done_clear", 32'(o_done), 32'd0);
    tick();

    // Load one-entry y-fast READ/LOOP_END program in IDLE
    i_ucode_we = 1'b1;
    i_ucode_addr = 4'd0;
    i_ucode_wdata = 12'h03A;
    tick();
    i_ucode_we = 1'b0;
    check("load_rdback", 32'(o_ucode_rdata), 32'h03A);

    i_start = 1'b1;
    tick();
    check("yf_start_op", 32'(o_op_cmd), 32'd0);
    for (int a = 0; a < 16; a++) push(2'd2, a, 2'b00, 1'b1);
    for (int a = 0; a < 16; a++) push(2'd2, a, 2'b11, 1'b1);
    run_queue("yf");
    q.delete();
    tick();
    check("yf_end_op", 32'(o_op_cmd), 32'd0);
    check("yf_done", 32'(o_done), 32'd1);

    i_start = 1'b0;
    repeat (2) tick();
    i_start = 1'b1;
    repeat (12) tick();
    check("midrun_op_nonzero", 32'(o_op_cmd != 2'd0), 32'd1);

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    check("arst_op", 32'(o_op_cmd), 32'd0);
    check("arst_x", 32'(o_addr_x), 32'd0);
    check("arst_y", 32'(o_addr_y), 32'd0);
    check("arst_data", 32'(o_data), 32'd0);
    check("arst_done", 32'(o_done), 32'd0);
    check("arst_rom_revert", 32'(o_ucode_rdata), 32'h011);
    #1;
    rst_n = 1'b1;
    tick();
    check("restart_idle_op", 32'(o_op_cmd), 32'd0);
    push(2'd1, 0, 2'b00, 1'b0);
    push(2'd1, 1, 2'b00, 1'b0);
    push(2'd1, 2, 2'b00, 1'b0);
    run_queue("restart");
    q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmbist_microcode_container.md
# pmbist_microcode_container

Programmable memory-BIST sequencer. It holds a small writable microcode store and executes one instruction per clock. Each cycle it emits one memory operation (NOP/WRITE/READ), an X/Y address and the write or expected-read data. It sits between the BIST control interface and the memory wrapper. A March-style X-scan program is preloaded at reset, so the block runs with no load step.

## Interface
Parameters:
- AX_WIDTH, 2: X (row) address bits.
- AY_WIDTH, 2: Y (column) address bits.
- D_WIDTH, 2: data width.
- UC_DEPTH, 16: microcode entries. UA_W = log2(UC_DEPTH).
- UC_W, 12: instruction width.

Ports (positional order is fixed):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_ucode_we  in  1  microcode write strobe. Honoured only when idle.
- i_ucode_addr  in  UA_W  microcode write/readback index.
- i_ucode_wdata  in  UC_W  microcode write data.
- o_ucode_rdata  out  UC_W  combinational readback of store[i_ucode_addr].
- i_start  in  1  level run request.
- o_op_cmd  out  2  pmbist::t_op_cmd: NOP=0, WRITE=1, READ=2.
- o_addr_x  out  AX_WIDTH  row address.
- o_addr_y  out  AY_WIDTH  column address.
- o_data  out  D_WIDTH  write data, or expected data on READ.
- o_done  out  1  program complete.

## Operation
- Instruction fields:
  - [1:0] op: 0 NOP, 1 WRITE, 2 READ, 3 treated as NOP.
  - [2] dinv: invert data.
  - [3] y_fast: address mapping.
  - [5:4] flow.
  - [9:6] tgt.
  - [10] dir_flip.
  - [11] reserved, must be 0.
- State:
  - pc (UA_W bits).
  - Address index idx (AX_WIDTH+AY_WIDTH bits).
  - dir: 0 up, 1 down.
  - bg_inv: pass bit.
  - FSM IDLE/RUN/DONE.
- Address mapping:
  - y_fast=0: addr_x = idx[AX-1:0], addr_y = idx[top bits].
  - y_fast=1: addr_y = idx low bits, addr_x = high bits.
- Data: o_data = {D_WIDTH{bg_inv ^ dinv}`}`. Background is all-zeros; pass 2 uses all-ones.
- flow=0 NEXT:
  - pc+1.
  - If dir_flip: toggle dir and set idx to first of the new direction (0 up, max down).
  - NEXT at pc = UC_DEPTH-1 goes to DONE.
- flow=1 LOOP:
  - If idx is not last (max when up, 0 when down): idx±1 and pc = tgt.
  - Else: apply dir_flip if set, set idx to first of dir, and pc+1.
- flow=2 JUMP: pc = tgt. idx is unchanged.
- flow=3 LOOP_END:
  - Not last: same as LOOP.
  - Last with bg_inv=0: bg_inv=1, dir=up, idx=0, pc=0.
  - Last with bg_inv=1: go to DONE.
- Reset contents of the store (op, dinv, flow, tgt, flip; y_fast=0 throughout):
  - 0: W,0,LOOP,0
  - 1: R,0,NEXT
  - 2: W,1,LOOP,1,flip
  - 3: NOP,NEXT
  - 4: R,1,NEXT
  - 5: W,0,LOOP,4,flip
  - 6: NOP,NEXT
  - 7: R,0,LOOP_END,7
  - 8–15: NOP,NEXT
- FSM transitions:
  - IDLE→RUN when i_start=1 (pc=0, idx=0, dir=up, bg_inv=0).
  - DONE→IDLE when i_start=0.
  - Writes while RUN or DONE are ignored.

## Timing
- Reset state:
  - All outputs are registered; reset value is o_op_cmd=NOP, address 0, o_data 0, o_done 0.
  - pc, idx, dir and bg_inv are 0; FSM is IDLE.
  - Reset mid-run aborts immediately. Store contents revert to the default program.
- Execution:
  - Each rising edge in RUN registers the current instruction's op, address and data onto the outputs and advances state. Latency is one edge per operation.
  - With i_start tied high, the first edge after rst_n rises moves IDLE→RUN. The next edge presents WRITE x0 y0 d0.
  - The default program issues 98 ops per pass and 196 ops in total.
  - The edge after the last READ drives o_op_cmd=NOP and o_done=1. o_done holds until i_start=0.
- Microcode writes: a write at a rising edge with i_ucode_we=1 in IDLE is visible on o_ucode_rdata after that edge.

## Test plan
- Default run, pass 0 write phase → 16 WRITEs with d=0, x incrementing inside y, (0,0)…(3,3).
- Read/modify phase (up) → READ q=0, then WRITE d=3 at the same address, ×16. Followed by one NOP.
- Down phase → pairs READ q=3 / WRITE d=0 from (3,3) to (0,0), one NOP, then 16 READ q=0 going up.
- Pass 1 → identical sequence with data inverted (first WRITE d=3). o_done=1 after op 196; o_done clears when i_start drops.
- Load a one-entry program {R, LOOP_END, tgt0, y_fast=1} → 16 READs with y fast and q=0, then 16 with q=3, then done.
- rst_n pulsed mid-run with i_start held high → outputs return to NOP/0, and the program restarts at WRITE (0,0), d=0.
